// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART byte transmitter between two byte requesters.
// Optional WAIT timeout/abort is enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int TIMEOUT_CLKS = 600000,
    parameter int CNT_W        = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] i_ARB_Baud,
    input  logic       i_REQ0_Req,
    input  logic [7:0] i_REQ0_Din,
    output logic       o_REQ0_Ack,
    output logic       o_REQ0_Done,
    input  logic       i_REQ1_Req,
    input  logic [7:0] i_REQ1_Din,
    output logic       o_REQ1_Ack,
    output logic       o_REQ1_Done,
    output logic [7:0] o_TXD_Din,
    output logic       o_TXD_En,
    output logic [2:0] o_TXD_Baud,
    input  logic       i_TXD_Done,
    output logic       o_ARB_Busy,
    output logic       o_ARB_Owner
`ifdef UART_TX_ARB_TIMEOUT_EN
    ,
    output logic       o_ARB_Timeout
`endif
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t     r_state;
    logic [7:0] r_txd_din;
    logic       r_txd_en;
    logic [1:0] r_ack;
    logic [1:0] r_done;
    logic       r_busy;
    logic       r_owner;
    logic       r_last;
    logic       r_guard;

    state_t     w_state_next;
    logic [7:0] w_txd_din_next;
    logic       w_txd_en_next;
    logic [1:0] w_ack_next;
    logic [1:0] w_done_next;
    logic       w_busy_next;
    logic       w_owner_next;
    logic       w_last_next;
    logic       w_guard_next;
    logic       w_winner;

    if ((64'd1 << CNT_W) <= 64'(TIMEOUT_CLKS)) begin : g_cnt_w_check
        $error("CNT_W too narrow for TIMEOUT_CLKS");
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_timeout_next;
`endif

    // On contention the requester that was not served last wins.
    assign w_winner = (i_REQ0_Req && i_REQ1_Req) ? ~r_last : i_REQ1_Req;

    always_comb begin
        w_state_next   = r_state;
        w_txd_din_next = r_txd_din;
        w_txd_en_next  = 1'b0;
        w_ack_next     = 2'b00;
        w_done_next    = 2'b00;
        w_busy_next    = r_busy;
        w_owner_next   = r_owner;
        w_last_next    = r_last;
        w_guard_next   = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
        w_cnt_next     = r_cnt;
        w_timeout_next = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_busy_next = 1'b0;
                if (i_REQ0_Req || i_REQ1_Req) begin
                    w_txd_din_next       = w_winner ? i_REQ1_Din : i_REQ0_Din;
                    w_txd_en_next        = 1'b1;
                    w_ack_next[w_winner] = 1'b1;
                    w_owner_next         = w_winner;
                    w_last_next          = w_winner;
                    w_busy_next          = 1'b1;
                    w_guard_next         = 1'b1;
                    w_state_next         = S_WAIT;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    w_cnt_next           = '0;
`endif
                end
            end
            S_WAIT: begin
                // A Done seen in the grant-cycle+1 slot cannot belong to this byte.
                if (!r_guard && i_TXD_Done) begin
                    w_done_next[r_owner] = 1'b1;
                    w_busy_next          = 1'b0;
                    w_state_next         = S_IDLE;
                end
`ifdef UART_TX_ARB_TIMEOUT_EN
                else if (r_cnt == CNT_W'(TIMEOUT_CLKS - 1)) begin
                    w_timeout_next = 1'b1;
                    w_busy_next    = 1'b0;
                    w_state_next   = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
`endif
            end
            default: begin
                w_state_next = S_IDLE;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_txd_din <= 8'h00;
            r_txd_en  <= 1'b0;
            r_ack     <= 2'b00;
            r_done    <= 2'b00;
            r_busy    <= 1'b0;
            r_owner   <= 1'b0;
            r_last    <= 1'b1;
            r_guard   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_txd_din <= w_txd_din_next;
            r_txd_en  <= w_txd_en_next;
            r_ack     <= w_ack_next;
            r_done    <= w_done_next;
            r_busy    <= w_busy_next;
            r_owner   <= w_owner_next;
            r_last    <= w_last_next;
            r_guard   <= w_guard_next;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_timeout <= w_timeout_next;
        end
    end

    assign o_ARB_Timeout = r_timeout;
`endif

    assign o_REQ0_Ack  = r_ack[0];
    assign o_REQ1_Ack  = r_ack[1];
    assign o_REQ0_Done = r_done[0];
    assign o_REQ1_Done = r_done[1];
    assign o_TXD_Din   = r_txd_din;
    assign o_TXD_En    = r_txd_en;
    assign o_TXD_Baud  = i_ARB_Baud;
    assign o_ARB_Busy  = r_busy;
    assign o_ARB_Owner = r_owner;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised scoreboard bench for uart_tx_arbiter with a simple byte-transmitter stand-in.
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] baud;
    logic       req0, req1;
    logic [7:0] din0, din1;
    logic       txd_done;
    logic       ack0, ack1, done0, done1;
    logic [7:0] txd_din;
    logic       txd_en, busy, owner;
    logic [2:0] txd_baud;
    logic [1:0] ack, dn;
`ifdef UART_TX_ARB_TIMEOUT_EN
    logic       tmo;
`endif

    assign ack = {ack1, ack0};
    assign dn  = {done1, done0};

    uart_tx_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_ARB_Baud (baud),
        .i_REQ0_Req (req0),
        .i_REQ0_Din (din0),
        .o_REQ0_Ack (ack0),
        .o_REQ0_Done(done0),
        .i_REQ1_Req (req1),
        .i_REQ1_Din (din1),
        .o_REQ1_Ack (ack1),
        .o_REQ1_Done(done1),
        .o_TXD_Din  (txd_din),
        .o_TXD_En   (txd_en),
        .o_TXD_Baud (txd_baud),
        .i_TXD_Done (txd_done),
        .o_ARB_Busy (busy),
        .o_ARB_Owner(owner)
`ifdef UART_TX_ARB_TIMEOUT_EN
        ,
        .o_ARB_Timeout(tmo)
`endif
    );

    always #10 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    bit run = 0;
    bit hold_done = 0;

    task automatic fail_chk(input string name, input int act, input int exp);
        n_vec++;
        n_bad++;
        $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        if (act != exp) fail_chk(name, act, exp);
        else n_vec++;
    endtask

    // Reference model: one byte in flight at a time; a grant happens whenever the
    // transmitter is free and someone asks; on contention the one not served last wins;
    // a byte completes on the first Done that arrives after the grant cycle has passed.
    typedef struct packed {
        logic       owner;
        logic [7:0] data;
    } grant_t;

    grant_t gq[$];
    bit     dq[$];
    bit     m_busy, m_last, m_owner;
    int     m_age;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  = 0;
            m_last  = 1;
            m_owner = 0;
            m_age   = 0;
            gq.delete();
            dq.delete();
        end else if (m_busy) begin
            if (m_age > 0 && txd_done) begin
                dq.push_back(m_owner);
                m_busy = 0;
            end
            m_age++;
        end else if (req0 || req1) begin
            grant_t g;
            if (req0 && req1) g.owner = !m_last;
            else g.owner = req1;
            g.data  = g.owner ? din1 : din0;
            gq.push_back(g);
            m_owner = g.owner;
            m_last  = g.owner;
            m_busy  = 1;
            m_age   = 0;
        end
    end

    // Monitor: pops expectations whenever the DUT presents an Ack/En or Done.
    always @(negedge clk) begin
        if (rst_n) begin
            grant_t g;
            bit     d;
            chk("busy", busy, m_busy);
            chk("owner", owner, m_owner);
            chk("baud", txd_baud, baud);
`ifdef UART_TX_ARB_TIMEOUT_EN
            chk("timeout", tmo, 0);
`endif
            if (ack != 2'b00 || txd_en) begin
                if (gq.size() == 0) begin
                    fail_chk("unexpected_grant", {txd_en, ack}, 0);
                end else begin
                    g = gq.pop_front();
                    chk("ack", ack, g.owner ? 2 : 1);
                    chk("txd_en", txd_en, 1);
                    chk("txd_din", txd_din, g.data);
                end
            end else if (gq.size() != 0) begin
                g = gq.pop_front();
                fail_chk("missing_grant", 0, g.owner ? 2 : 1);
            end
            if (dn != 2'b00) begin
                if (dq.size() == 0) begin
                    fail_chk("unexpected_done", dn, 0);
                end else begin
                    d = dq.pop_front();
                    chk("done", dn, d ? 2 : 1);
                end
            end else if (dq.size() != 0) begin
                d = dq.pop_front();
                fail_chk("missing_done", 0, d ? 2 : 1);
            end
        end
    end

    // Byte transmitter stand-in: Done 1..12 cycles after En, with occasional
    // glitches in the guard cycle and stray pulses while idle.
    int cd = 0;
    always @(negedge clk) begin
        txd_done = 1'b0;
        if (!rst_n) begin
            cd = 0;
        end else begin
            if (cd > 0) begin
                cd--;
                if (cd == 0) txd_done = 1'b1;
            end else if (!busy && $urandom_range(0, 30) == 0) begin
                txd_done = 1'b1;
            end
            if (txd_en && !hold_done) begin
                cd = $urandom_range(1, 12);
                if ($urandom_range(0, 3) == 0) txd_done = 1'b1;
            end
        end
    end

    task automatic drive_req(input int idx, input logic r, input logic [7:0] d);
        if (idx == 0) begin
            req0 = r;
            din0 = d;
        end else begin
            req1 = r;
            din1 = d;
        end
    endtask

    task automatic requester(input int idx);
        int limit;
        bit got;
        forever begin
            while (!run) @(negedge clk);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            if (run) begin
                drive_req(idx, 1'b1, 8'($urandom));
                do begin
                    limit = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 300;
                    got = 0;
                    for (int k = 0; k < limit && !got; k++) begin
                        @(negedge clk);
                        got = ack[idx];
                    end
                    if (!got && limit == 300) fail_chk("ack_timeout", idx, 1);
                    if (got && run && $urandom_range(0, 1) == 1) begin
                        drive_req(idx, 1'b1, 8'($urandom));
                    end else begin
                        drive_req(idx, 1'b0, 8'h00);
                        got = 0;
                    end
                end while (got);
            end
        end
    endtask

    task automatic wait_ack(input int idx, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (ack[idx]) return;
        end
        fail_chk("wait_ack", idx, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (!req0 && !req1 && !busy && gq.size() == 0 && dq.size() == 0) return;
        end
        fail_chk("drain", busy, 0);
    endtask

    task automatic random_phase(input int cycles);
        run = 1;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #2;
            if ($urandom_range(0, 99) == 0) baud = 3'($urandom);
        end
        run = 0;
        drain();
    endtask

    task automatic check_all_zero();
        chk("rst_txd_din", txd_din, 0);
        chk("rst_txd_en", txd_en, 0);
        chk("rst_ack", ack, 0);
        chk("rst_done", dn, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
`ifdef UART_TX_ARB_TIMEOUT_EN
        chk("rst_timeout", tmo, 0);
`endif
    endtask

    initial begin
        req0 = 0; req1 = 0; din0 = 0; din1 = 0;
        baud = 3'd4; txd_done = 0;
        fork
            requester(0);
            requester(1);
        join_none
        repeat (3) @(negedge clk);
        check_all_zero();
        #3 rst_n = 1'b1;

        // Simultaneous requests after reset: requester 0 goes first.
        @(negedge clk);
        drive_req(0, 1'b1, 8'hAA);
        drive_req(1, 1'b1, 8'h55);
        wait_ack(0, 5);
        drive_req(0, 1'b0, 8'h00);
        wait_ack(1, 40);
        drive_req(1, 1'b0, 8'h00);
        drain();

        random_phase(3000);

        // Reset in the middle of a transfer, then requester 1 alone is served.
        hold_done = 1;
        @(negedge clk);
        drive_req(0, 1'b1, 8'hAA);
        wait_ack(0, 5);
        drive_req(0, 1'b0, 8'h00);
        repeat (20) @(negedge clk);
        chk("busy_before_rst", busy, 1);
        #3 rst_n = 1'b0;
        #1 check_all_zero();
        drive_req(1, 1'b1, 8'h55);
        @(negedge clk);
        #3 rst_n = 1'b1;
        hold_done = 0;
        wait_ack(1, 5);
        drive_req(1, 1'b0, 8'h00);
        drain();

        random_phase(2000);

        chk("grant_queue_empty", gq.size(), 0);
        chk("done_queue_empty", dq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        repeat (50000) @(posedge clk);
        fail_chk("watchdog", 0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
